// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, default reset PC and a NOP word.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // addi x0, x0, 0 -- handy filler for debug displays
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pc_reg.sv
// Architectural PC register: asynchronous reset to RESET_PC, loads d when load is high.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Hold unless a retire asks for a load
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = d;
        end
    end

    // PC flop with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q = pc_q;

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: requests the instruction at pc, latches the response and holds it
// for decode until it retires, then advances pc to npc (or halts on a misaligned npc).
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      npc,
    output logic [31:0]      pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    input  logic             inst_ready,
    output logic             fetch_err,
    output logic [CNT_W-1:0] retire_cnt
);

    fetch_state_t     state_q, state_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      inst_pc_q, inst_pc_d;
    logic             inst_valid_q, inst_valid_d;
    logic             fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             pc_load;
    logic             req_d;
    logic [31:0]      pc_q;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (npc),
        .q    (pc_q)
    );

    // Next-state, instruction latch, retire counter and request output
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fetch_err_d  = fetch_err_q;
        retire_cnt_d = retire_cnt_q;
        pc_load      = 1'b0;
        req_d        = 1'b0;
        case (state_q)
            S_REQ: begin
                req_d = 1'b1;
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    retire_cnt_d = retire_cnt_q + CNT_W'(1);
                    if (npc[1:0] == 2'b00) begin
                        pc_load = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        // Misaligned target: keep the old pc and stop fetching until reset
                        fetch_err_d = 1'b1;
                        state_d     = S_HALT;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            inst_q       <= 32'h0;
            inst_pc_q    <= RESET_PC;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign imem_req   = req_d;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = fetch_err_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a memory model driven from the bench, a scoreboard of
// expected {inst, inst_pc} pushed when rdata is returned and popped at retire.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_err;
    logic [31:0] retire_cnt;

    int vectors;
    int miscompares;

    logic [63:0] sb[$];
    logic [31:0] model_pc;
    logic [31:0] model_cnt;
    logic        model_err;

    pc_fetch #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .fetch_err   (fetch_err),
        .retire_cnt  (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sampled at the negedge on entry to each cycle: status that is valid in every state
    task automatic chk_status(input string tag);
        chk({tag, ".pc"}, pc, model_pc);
        chk({tag, ".addr"}, imem_addr, model_pc);
        chk({tag, ".cnt"}, retire_cnt, model_cnt);
        chk({tag, ".err"}, {31'h0, fetch_err}, {31'h0, model_err});
    endtask

    // One full instruction: gnt after gnt_dly cycles, rvalid after rv_dly cycles,
    // decode stalls for stall cycles, then retires with npc_v.
    task automatic fetch(input string tag, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata, input int stall, input logic [31:0] npc_v);
        logic [63:0] exp;
        for (int i = 0; i <= gnt_dly; i++) begin
            @(negedge clk);
            chk_status({tag, ".req"});
            chk({tag, ".req.req"}, {31'h0, imem_req}, 32'h1);
            chk({tag, ".req.vld"}, {31'h0, inst_valid}, 32'h0);
            imem_gnt    = (i == gnt_dly);
            imem_rvalid = (i < gnt_dly);          // stray response while requesting
            imem_rdata  = 32'hDEAD_0000 | i;
            inst_ready  = 1'b1;                   // stray ready outside HOLD
            npc         = $urandom;
        end
        for (int i = 0; i <= rv_dly; i++) begin
            @(negedge clk);
            chk_status({tag, ".wait"});
            chk({tag, ".wait.req"}, {31'h0, imem_req}, 32'h0);
            chk({tag, ".wait.vld"}, {31'h0, inst_valid}, 32'h0);
            imem_gnt    = (i < rv_dly);           // stray grant while waiting
            imem_rvalid = (i == rv_dly);
            imem_rdata  = (i == rv_dly) ? rdata : 32'hBAD0_0000 | i;
            inst_ready  = 1'b1;
            npc         = $urandom;
            if (i == rv_dly) sb.push_back({rdata, model_pc});
        end
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            chk_status({tag, ".hold"});
            chk({tag, ".hold.req"}, {31'h0, imem_req}, 32'h0);
            chk({tag, ".hold.vld"}, {31'h0, inst_valid}, 32'h1);
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'h1, 32'h0);
            end else begin
                exp = sb[0];
                chk({tag, ".inst"}, inst, exp[63:32]);
                chk({tag, ".inst_pc"}, inst_pc, exp[31:0]);
            end
            imem_gnt    = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hFACE_0000 | i;
            inst_ready  = (i == stall);
            npc         = (i == stall) ? npc_v : ($urandom | 32'h1);
        end
        if (sb.size() != 0) void'(sb.pop_front());
        model_cnt++;
        if (npc_v[1:0] == 2'b00) model_pc = npc_v;
        else model_err = 1'b1;
    endtask

    task automatic model_reset();
        model_pc  = 32'h0;
        model_cnt = 32'h0;
        model_err = 1'b0;
        sb.delete();
    endtask

    // Asserts rst away from any clock edge and checks the outputs settle without a clock
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_status({tag, ".rst"});
        chk({tag, ".rst.vld"}, {31'h0, inst_valid}, 32'h0);
        chk({tag, ".rst.inst"}, inst, 32'h0);
        chk({tag, ".rst.inst_pc"}, inst_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        npc         = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.vld", {31'h0, inst_valid}, 32'h0);
        chk("reset.inst_pc", inst_pc, 32'h0);
        chk_status("reset");
        rst = 1'b0;

        // Zero-wait memory: valid in cycle 3, pc=4 and count=1 in cycle 4
        fetch("zw", 0, 0, 32'h0010_0093, 0, 32'h0000_0004);
        // Slow memory: gnt after 2, rvalid after 3
        fetch("slow", 2, 3, 32'h1234_5678, 0, 32'h0000_0010);
        // Back-pressure for 5 cycles with toggling npc, then branch to 0x100
        fetch("bp", 0, 0, 32'h0000_0013, 5, 32'h0000_0100);
        // Instruction at the branch target
        fetch("tgt", 0, 1, 32'hABCD_EF01, 0, 32'h0000_0104);
        // Misaligned retire: halt with error
        fetch("mis", 1, 0, 32'h5555_AAAA, 0, 32'h0000_0102);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_status("halt");
            chk("halt.req", {31'h0, imem_req}, 32'h0);
            chk("halt.vld", {31'h0, inst_valid}, 32'h0);
            imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ready = 1'b1;
            npc = 32'h0000_0200;
        end

        // Reset clears the error and restarts at RESET_PC
        pulse_reset("halt_rst");
        fetch("after_halt", 0, 0, 32'h0000_1111, 0, 32'h0000_0008);

        // Reset in the middle of S_WAIT, stale rvalid right after release
        @(negedge clk);
        chk_status("mid.req");
        imem_gnt = 1'b1; imem_rvalid = 1'b0; inst_ready = 1'b0;
        @(negedge clk);
        chk("mid.wait.req", {31'h0, imem_req}, 32'h0);
        imem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_status("mid.rst");
        chk("mid.rst.req", {31'h0, imem_req}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBADB_AD00;
        @(negedge clk);
        chk("stale.vld", {31'h0, inst_valid}, 32'h0);
        chk("stale.req", {31'h0, imem_req}, 32'h1);
        chk_status("stale");
        imem_rvalid = 1'b0;
        fetch("fresh", 0, 0, 32'h0020_0113, 2, 32'h0000_0004);
        @(negedge clk);
        chk_status("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
